div_sequencer: RTL and testbench

Multi-cycle sequencer and datapath for the RV32M divide group: DIV, DIVU, REM, REMU. It sits beside the ALU in the EX stage and accepts a divide request when the decoded instruction reaches EX. It runs a radix-2 restoring division over XLEN cycles and drives `Stall` into `control_unit` and the pipeline registers until the result is ready. Results, including the RISC-V divide-by-zero and overflow special cases, are returned on a one-cycle valid pulse.

---
 rtl/rv32im_pkg.sv | 37 +++
 rtl/div_step.sv | 32 +++
 rtl/div_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_div_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32im_pkg.sv
// rv32im_pkg: shared RV32M divide-group encodings, FSM state type and width default.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DIVOP_* op encodings, div_state_t, XLEN_DEFAULT, op decode helpers.
package rv32im_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Divide-group op select as presented by decode (funct3[1:0] order).
  localparam logic [1:0] DIVOP_DIV  = 2'b00;
  localparam logic [1:0] DIVOP_DIVU = 2'b01;
  localparam logic [1:0] DIVOP_REM  = 2'b10;
  localparam logic [1:0] DIVOP_REMU = 2'b11;

  // Fixed encodings kept as plain constants so older tooling/scripts that
  // decode the state bits keep working.
  localparam logic [1:0] DIV_ST_IDLE = 2'd0;
  localparam logic [1:0] DIV_ST_BUSY = 2'd1;
  localparam logic [1:0] DIV_ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    DIV_IDLE = DIV_ST_IDLE,
    DIV_BUSY = DIV_ST_BUSY,
    DIV_DONE = DIV_ST_DONE
  } div_state_t;

  // DIV and REM treat operands as two's complement.
  function automatic logic divop_is_signed(input logic [1:0] op);
    return (op == DIVOP_DIV) || (op == DIVOP_REM);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic divop_is_rem(input logic [1:0] op);
    return (op == DIVOP_REM) || (op == DIVOP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division iteration (shift, trial-subtract, restore).
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides whether to register it.
// Ports: rem_in/quo_in - current partial remainder and quotient/dividend shift register,
//        divisor - unsigned divisor magnitude, rem_out/quo_out - next-iteration values.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  // The shifted remainder needs one extra bit: with an unsigned divisor
  // above 2^(XLEN-1), 2*rem+1 can exceed XLEN bits before the subtract.
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] diff;
  logic            borrow;

  always_comb begin
    rem_sh  = {rem_in, quo_in[XLEN-1]};
    borrow  = rem_sh < {1'b0, divisor};
    // When there is no borrow the true difference is below the divisor,
    // so the low XLEN bits of the modular subtract are exact.
    diff    = rem_sh[XLEN-1:0] - divisor;
    rem_out = borrow ? rem_sh[XLEN-1:0] : diff;
    quo_out = {quo_in[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: RV32M DIV/DIVU/REM/REMU multi-cycle sequencer and restoring-division datapath.
// Latency: XLEN+1 cycles from accept to result_valid; 1 cycle for divide-by-zero, signed overflow or a cache hit.
// Backpressure: never stalled itself; drives Stall to freeze the pipeline while a divide is pending, flush aborts.
//
// Ports:
//   CLK, RESET        - rising-edge clock, synchronous active-high reset
//   start, op         - divide-group instruction in EX and its op select (DIVOP_*)
//   operand_a/_b      - dividend (rs1) and divisor (rs2) after forwarding
//   flush             - kill the EX instruction; aborts any divide in flight
//   Stall             - combinational pipeline freeze request
//   busy              - FSM is not IDLE
//   result_valid      - one-cycle pulse, result is meaningful only in that cycle
//   result            - quotient or remainder selected by the latched op
//
// Build option: define DIV_RESULT_CACHE_EN to keep the last completed divide
// (a, b, signedness, quotient and remainder) so a repeat of the same operands
// (e.g. DIV followed by REM) finishes in one cycle.
module div_sequencer
  import rv32im_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            Stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  rem_q;      // partial remainder
  logic [XLEN-1:0]  quo_q;      // dividend shifting out, quotient shifting in
  logic [XLEN-1:0]  dvsr_q;     // |b|
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [XLEN-1:0]  result_q;   // last delivered result, held between pulses

  // ---------------------------------------------------------------------------
  // Accept-cycle decode
  // ---------------------------------------------------------------------------
  logic            in_signed;
  logic            accept;
  logic            b_zero;
  logic            s_ovf;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  assign in_signed = divop_is_signed(op);
  assign accept    = (state_q == DIV_IDLE) && start && !flush;
  assign b_zero    = (operand_b == '0);
  assign s_ovf     = in_signed && (operand_a == INT_MIN) && (operand_b == '1);

  // INT_MIN negates to itself, which is the correct unsigned magnitude.
  assign abs_a = (in_signed && operand_a[XLEN-1]) ? -operand_a : operand_a;
  assign abs_b = (in_signed && operand_b[XLEN-1]) ? -operand_b : operand_b;

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  div_step #(
    .XLEN (XLEN)
  ) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // ---------------------------------------------------------------------------
  // Sign correction and result select (DONE cycle)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] final_sel;
  logic            done_ok;

  // Magnitudes are at most 2^(XLEN-1) whenever a sign flag is set, so the
  // negation cannot overflow.
  assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix   = neg_rem_q ? -rem_q : rem_q;
  assign final_sel = divop_is_rem(op_q) ? rem_fix : quo_fix;
  assign done_ok   = (state_q == DIV_DONE) && !flush;

  // ---------------------------------------------------------------------------
  // Optional result cache
  // ---------------------------------------------------------------------------
  logic            cache_hit;
  logic [XLEN-1:0] hit_quo;
  logic [XLEN-1:0] hit_rem;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_vld_q;
  logic            cache_signed_q;
  logic [XLEN-1:0] cache_a_q;
  logic [XLEN-1:0] cache_b_q;
  logic [XLEN-1:0] cache_quo_q;
  logic [XLEN-1:0] cache_rem_q;
  logic [XLEN-1:0] a_q;         // raw operands of the divide in flight
  logic [XLEN-1:0] b_q;

  // Quotient and remainder of one divide are both kept, so DIV/REM pairs
  // hit regardless of which one came first; signedness must match.
  assign cache_hit = cache_vld_q
                  && (cache_a_q == operand_a)
                  && (cache_b_q == operand_b)
                  && (cache_signed_q == in_signed);
  assign hit_quo   = cache_quo_q;
  assign hit_rem   = cache_rem_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cache_vld_q    <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
      a_q            <= '0;
      b_q            <= '0;
    end else begin
      if (accept) begin
        a_q <= operand_a;
        b_q <= operand_b;
      end
      if (flush && (state_q != DIV_IDLE)) begin
        cache_vld_q <= 1'b0;
      end else if (done_ok) begin
        cache_vld_q    <= 1'b1;
        cache_signed_q <= divop_is_signed(op_q);
        cache_a_q      <= a_q;
        cache_b_q      <= b_q;
        cache_quo_q    <= quo_fix;
        cache_rem_q    <= rem_fix;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_quo   = '0;
  assign hit_rem   = '0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            op_q      <= op;
            cnt_q     <= CNT_LAST;
            dvsr_q    <= abs_b;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            state_q   <= DIV_DONE;
            // Short-cut cases load the final values directly with the sign
            // flags cleared, so DONE passes them through untouched.
            if (b_zero) begin
              quo_q <= '1;
              rem_q <= operand_a;
            end else if (s_ovf) begin
              quo_q <= INT_MIN;
              rem_q <= '0;
            end else if (cache_hit) begin
              quo_q <= hit_quo;
              rem_q <= hit_rem;
            end else begin
              quo_q     <= abs_a;
              rem_q     <= '0;
              neg_quo_q <= in_signed && (operand_a[XLEN-1] ^ operand_b[XLEN-1]);
              neg_rem_q <= in_signed && operand_a[XLEN-1];
              state_q   <= DIV_BUSY;
            end
          end
        end

        DIV_BUSY: begin
          if (flush) begin
            state_q <= DIV_IDLE;
          end else begin
            quo_q <= step_quo;
            rem_q <= step_rem;
            // The step taken with cnt_q==0 is the last of XLEN iterations.
            if (cnt_q == '0) begin
              state_q <= DIV_DONE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end

        DIV_DONE: begin
          // start is ignored here: it is still the same instruction in EX.
          state_q <= DIV_IDLE;
          if (!flush) begin
            result_q <= final_sel;
          end
        end

        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Stall is low in DONE so the pipeline advances as the result is written.
  assign Stall        = accept || ((state_q == DIV_BUSY) && !flush);
  assign busy         = (state_q != DIV_IDLE);
  assign result_valid = done_ok;
  assign result       = done_ok ? final_sel : result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: self-checking bench for div_sequencer (table of vectors plus abort/cache sequences).
// Latency: expected latency comes from a small reference model (special cases, optional cache).
// Backpressure: start is held until the result pulse, as the pipeline would.
module tb_div_sequencer;
  import rv32im_pkg::*;

  localparam int XLEN = 32;

  logic             CLK;
  logic             RESET;
  logic             start;
  logic [1:0]       op;
  logic [XLEN-1:0]  operand_a;
  logic [XLEN-1:0]  operand_b;
  logic             flush;
  logic             Stall;
  logic             busy;
  logic             result_valid;
  logic [XLEN-1:0]  result;

  div_sequencer #(
    .XLEN (XLEN)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .op           (op),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .Stall        (Stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  // Reference model of the last completed divide (only matters with the cache).
  bit          m_vld;
  logic [31:0] m_a;
  logic [31:0] m_b;
  bit          m_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit is_signed_op(input logic [1:0] o);
    return (o == 2'b00) || (o == 2'b10);
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit s;
    s = is_signed_op(o);
    if (b == 32'd0) return 1;
    if (s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    if (CACHE_EN && m_vld && (m_a == a) && (m_b == b) && (m_s == s)) return 1;
    return 33;
  endfunction

  task automatic add_vec(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input string name);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.res = res; v.name = name;
    vecs.push_back(v);
  endtask

  // Issue one divide with start held, then watch for the pulse.
  task automatic do_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input string name);
    exp_t e;
    exp_t got;
    int   bad_stall;
    bit   seen;
    e.res  = exp_res;
    e.lat  = model_lat(o, a, b);
    e.name = name;
    @(posedge CLK); #1;
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    sb.push_back(e);
    bad_stall = 0;
    seen      = 1'b0;
    for (int n = 0; n <= 40 && !seen; n++) begin
      @(negedge CLK);
      if (result_valid === 1'b1) begin
        got  = sb.pop_front();
        seen = 1'b1;
        chk({got.name, " result"}, result, got.res);
        chk({got.name, " latency"}, 32'(n), 32'(got.lat));
        chk({got.name, " stall_in_done"}, 32'(Stall), 32'd0);
        start = 1'b0;
      end else if (Stall !== 1'b1) begin
        bad_stall++;
      end
    end
    if (!seen) begin
      got   = sb.pop_front();
      start = 1'b0;
      chk({got.name, " timeout_no_result_valid"}, 32'hFFFF_FFFF, 32'(got.lat));
    end
    chk({name, " stall_low_cycles"}, 32'(bad_stall), 32'd0);
    m_vld = 1'b1;
    m_a   = a;
    m_b   = b;
    m_s   = is_signed_op(o);
  endtask

  // Start a DIVU and kill it in cycle t+10 with flush or RESET.
  task automatic abort_div(input bit use_reset);
    int seen;
    @(posedge CLK); #1;
    op        = DIVOP_DIVU;
    operand_a = 32'd1000;
    operand_b = 32'd3;
    start     = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    if (use_reset) begin
      RESET = 1'b1;
      start = 1'b0;
    end else begin
      flush = 1'b1;
    end
    @(negedge CLK);
    if (!use_reset) begin
      chk("flush stall_in_flush_cycle", 32'(Stall), 32'd0);
      chk("flush busy_in_flush_cycle", 32'(busy), 32'd1);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    flush = 1'b0;
    start = 1'b0;
    m_vld = 1'b0;
    @(negedge CLK);
    chk(use_reset ? "reset busy_after" : "flush busy_after", 32'(busy), 32'd0);
    chk(use_reset ? "reset stall_after" : "flush stall_after", 32'(Stall), 32'd0);
    if (use_reset) begin
      chk("reset result_after", result, 32'd0);
      chk("reset result_valid_after", 32'(result_valid), 32'd0);
    end
    seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (result_valid === 1'b1) seen++;
    end
    chk(use_reset ? "reset no_result_pulse" : "flush no_result_pulse", 32'(seen), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    op        = 2'b00;
    operand_a = '0;
    operand_b = '0;
    m_vld     = 1'b0;
    m_a       = '0;
    m_b       = '0;
    m_s       = 1'b0;

    add_vec(DIVOP_DIVU, 32'd100,        32'd7,          32'd14,         "divu_100_7");
    add_vec(DIVOP_REMU, 32'd100,        32'd7,          32'd2,          "remu_100_7");
    add_vec(DIVOP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  "div_m7_2");
    add_vec(DIVOP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  "rem_m7_2");
    add_vec(DIVOP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  "div_5_0");
    add_vec(DIVOP_REM,  32'd5,          32'd0,          32'd5,          "rem_5_0");
    add_vec(DIVOP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "div_ovf");
    add_vec(DIVOP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "rem_ovf");
    add_vec(DIVOP_DIVU, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          "divu_big_divisor");
    add_vec(DIVOP_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  "remu_big_divisor");
    add_vec(DIVOP_DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  "div_100_m7");
    add_vec(DIVOP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          "rem_100_m7");
    add_vec(DIVOP_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         "div_m100_m7");
    add_vec(DIVOP_REM,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  "rem_m100_m7");
    add_vec(DIVOP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          "divu_no_ovf");
    add_vec(DIVOP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  "remu_no_ovf");
    add_vec(DIVOP_REMU, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  "remu_by_zero");
    add_vec(DIVOP_DIVU, 32'd0,          32'd0,          32'hFFFF_FFFF,  "divu_0_0");
    add_vec(DIVOP_DIV,  32'h1234_5678,  32'd1,          32'h1234_5678,  "div_by_one");
    add_vec(DIVOP_DIVU, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  "divu_deadbeef");
    add_vec(DIVOP_REMU, 32'hDEAD_BEEF,  32'h10,         32'hF,          "remu_deadbeef");
    add_vec(DIVOP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  "div_intmin_2");

    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("reset Stall", 32'(Stall), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset result", result, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_div(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].name);
    end

    abort_div(1'b0);
    do_div(DIVOP_DIVU, 32'd1000, 32'd3, 32'd333, "after_flush");
    abort_div(1'b1);
    do_div(DIVOP_DIVU, 32'd1000, 32'd3, 32'd333, "after_reset");

`ifdef DIV_RESULT_CACHE_EN
    do_div(DIVOP_DIV, 32'd100, 32'd7, 32'd14, "cache_fill_div");
    do_div(DIVOP_REM, 32'd100, 32'd7, 32'd2,  "cache_hit_rem");
    do_div(DIVOP_DIVU, 32'd100, 32'd7, 32'd14, "cache_signedness_miss");
    abort_div(1'b0);
    do_div(DIVOP_REMU, 32'd100, 32'd7, 32'd2, "cache_after_flush");
`endif

    repeat (2) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
